// File: rtl/pio_pulse_out.sv
// Avalon-MM output PIO: each channel is a static LEVEL bit OR'd with a
// self-clearing pulse from a per-channel down-counter.
module pio_pulse_out #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_LEN = 4,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_LEVEL = 3'd0;
  localparam logic [2:0] ADDR_SET   = 3'd1;
  localparam logic [2:0] ADDR_CLEAR = 3'd2;
  localparam logic [2:0] ADDR_PULSE = 3'd3;
  localparam logic [2:0] ADDR_LEN   = 3'd4;

  logic [WIDTH-1:0] level_q, level_d;
  logic [CNT_W-1:0] len_q, len_d, eff_len;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] busy, busy_d;
  logic [WIDTH-1:0] wd;
  logic             wr_en;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign eff_len   = (len_q == '0) ? CNT_W'(1) : len_q;
  // Upper writedata bits are don't-care for narrow configurations.
  assign unused_wd = ^writedata;

  // Next-state for LEVEL, LEN and the channel counters.
  always_comb begin
    level_d = level_q;
    len_d   = len_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
    end
    if (wr_en) begin
      case (address)
        ADDR_LEVEL: begin
          level_d = wd;
          for (int unsigned i = 0; i < WIDTH; i++) cnt_d[i] = '0;
        end
        ADDR_SET: level_d = level_q | wd;
        ADDR_CLEAR: begin
          level_d = level_q & ~wd;
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (wd[i]) cnt_d[i] = '0;
          end
        end
        ADDR_PULSE: begin
          // A reload overrides the decrement, so retriggers extend the pulse.
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (wd[i]) cnt_d[i] = eff_len;
          end
        end
        ADDR_LEN: len_d = writedata[CNT_W-1:0];
        default: ;
      endcase
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      busy[i]   = (cnt_q[i] != '0);
      busy_d[i] = (cnt_d[i] != '0);
    end
  end

  // State registers; out_port is registered from the next-state values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q  <= WIDTH'(RESET_VALUE);
      len_q    <= CNT_W'(DEFAULT_LEN);
      out_port <= WIDTH'(RESET_VALUE);
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      level_q  <= level_d;
      len_q    <= len_d;
      out_port <= level_d | busy_d;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Zero-wait-state read mux on current (pre-write) state.
  always_comb begin
    readdata = 32'h0;
    case (address)
      ADDR_LEVEL: readdata = 32'(out_port);
      ADDR_PULSE: readdata = 32'(busy);
      ADDR_LEN:   readdata = 32'(len_q);
      default:    readdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_pio_pulse_out.sv
// Bench for pio_pulse_out: cycle-by-cycle out_port scoreboard driven by a
// pulse-end-time model, plus directed register and pulse-width checks.
module tb_pio_pulse_out;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata, readdata1;
  logic [7:0]  out_port;
  logic [0:0]  out1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pio_pulse_out #(
    .WIDTH(8), .CNT_W(16), .DEFAULT_LEN(4), .RESET_VALUE(32'hA5)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  pio_pulse_out #(
    .WIDTH(1), .CNT_W(16), .DEFAULT_LEN(4), .RESET_VALUE(32'h0)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata1), .out_port(out1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a pulse is live while the edge count is below its end time.
  logic [7:0]  m_level;
  logic [15:0] m_len;
  int unsigned m_end [8];
  int unsigned cyc;
  logic [7:0]  exp_q [$];

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_level = 8'hA5;
      m_len   = 16'd4;
      cyc     = 0;
      foreach (m_end[i]) m_end[i] = 0;
      exp_q.delete();
    end else begin
      logic [7:0] exp_out;
      cyc++;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: begin m_level = writedata[7:0]; foreach (m_end[i]) m_end[i] = 0; end
          3'd1: m_level = m_level | writedata[7:0];
          3'd2: begin
            m_level = m_level & ~writedata[7:0];
            foreach (m_end[i]) if (writedata[i]) m_end[i] = 0;
          end
          3'd3: foreach (m_end[i])
                  if (writedata[i]) m_end[i] = cyc + ((m_len == 0) ? 1 : m_len);
          3'd4: m_len = writedata[15:0];
          default: ;
        endcase
      end
      exp_out = m_level;
      foreach (m_end[i]) if (m_end[i] > cyc) exp_out[i] = 1'b1;
      exp_q.push_back(exp_out);
    end
  end

  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) check("out_port_sb", 32'(out_port), 32'(exp_q.pop_front()));
  end

  // Called shortly after an edge; the write lands on the next edge and
  // returns 1ns after it.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a; #1;
    check(tag, readdata, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic count_high(input int b, output int n);
    n = 0;
    while (out_port[b] && n < 64) begin n++; step(); end
  endtask

  initial begin
    int n, m;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 32'(out_port), 32'hA5);
    rd("reset_len", 3'd4, 32'd4);
    rd("reset_busy", 3'd3, 32'd0);
    reset_n = 1'b1;
    step();

    // Level path
    wr(3'd0, 32'h0F); check("level_wr", 32'(out_port), 32'h0F);
    wr(3'd1, 32'h30); check("set_wr", 32'(out_port), 32'h3F);
    wr(3'd2, 32'h05); check("clear_wr", 32'(out_port), 32'h3A);
    rd("rd_set", 3'd1, 32'h0);
    rd("rd_clear", 3'd2, 32'h0);
    rd("rd_level", 3'd0, 32'h3A);
    step();
    wr(3'd0, 32'h00);

    // Pulse length
    wr(3'd4, 32'd3);
    wr(3'd3, 32'h01);
    rd("busy_len3", 3'd3, 32'h01);
    count_high(0, n);
    check("width_len3", 32'(n), 32'd3);
    #1 check("busy_after_len3", readdata, 32'h0);
    step();
    wr(3'd4, 32'd0);
    wr(3'd3, 32'h01);
    count_high(0, n);
    check("width_len0", 32'(n), 32'd1);

    // Retrigger
    wr(3'd4, 32'd10);
    n = 0;
    wr(3'd3, 32'h04);
    repeat (5) begin if (out_port[2]) n++; step(); end
    if (out_port[2]) n++;
    wr(3'd3, 32'h04);
    count_high(2, m);
    check("width_retrigger", 32'(n + m), 32'd16);

    // Cancel via CLEAR
    wr(3'd3, 32'h04);
    step(); step();
    check("pre_clear_high", 32'(out_port[2]), 32'd1);
    wr(3'd2, 32'h04);
    check("clear_cancel", 32'(out_port[2]), 32'd0);
    rd("clear_busy", 3'd3, 32'h0);

    // LEN change mid-pulse
    step();
    wr(3'd4, 32'd8);
    wr(3'd3, 32'h02);
    n = out_port[1] ? 1 : 0;
    wr(3'd4, 32'd2);
    count_high(1, m);
    check("width_len_change", 32'(n + m), 32'd8);
    rd("len_after_change", 3'd4, 32'd2);
    step();

    // LEVEL write cancels pulses
    wr(3'd3, 32'h0F);
    check("pulse_0_3", 32'(out_port), 32'h0F);
    wr(3'd0, 32'h00);
    check("level_cancel", 32'(out_port), 32'h00);
    rd("level_cancel_busy", 3'd3, 32'h0);
    step();

    // Address decode
    wr(3'd5, 32'hFF); wr(3'd6, 32'hFF); wr(3'd7, 32'hFF);
    check("unmapped_wr", 32'(out_port), 32'h00);
    rd("len_unchanged", 3'd4, 32'd2);
    rd("rd_addr5", 3'd5, 32'h0);
    rd("rd_addr6", 3'd6, 32'h0);
    rd("rd_addr7", 3'd7, 32'h0);
    step();
    wr(3'd0, 32'hFFFF_FFFE);
    check("width1_level", 32'(out1), 32'h0);
    check("width8_level", 32'(out_port), 32'hFE);

    // Async reset mid-pulse
    wr(3'd4, 32'd20);
    wr(3'd3, 32'hFF);
    check("pulse_all", 32'(out_port), 32'hFF);
    #2 reset_n = 1'b0;
    #1 check("async_reset", 32'(out_port), 32'hA5);
    rd("reset_busy_mid", 3'd3, 32'h0);
    reset_n = 1'b1;
    step(); step();
    check("no_resume", 32'(out_port), 32'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_pulse_out.md
# pio_pulse_out

Parametrised Avalon-MM output PIO for the Nios II control fabric. It drives WIDTH output lines, for example peak-detector resets and capture strobes. Each bit can be held at a static level or fired as a self-clearing pulse of programmable length. It replaces single-bit level-only PIOs, so firmware no longer has to issue a set-then-clear write pair to produce a strobe.

## Interface
Parameters:
- WIDTH, 8, number of output channels (1..32)
- CNT_W, 16, width of the pulse-length register and of each per-channel down-counter (1..32)
- DEFAULT_LEN, 4, reset value of the LEN register
- RESET_VALUE, 0, reset value of the LEVEL register (WIDTH bits)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low; clock clk
- address  in  3  Avalon word address
- chipselect  in  1  Avalon slave select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, combinational, zero wait states
- out_port  out  WIDTH  output lines, registered-derived, equal to LEVEL | BUSY

## Operation
- A write occurs on a clock edge where chipselect=1 and write_n=0. Only writedata[WIDTH-1:0] is used, except for LEN.
- Register map:
- addr 0 LEVEL: write loads LEVEL from writedata and cancels every active pulse (all counters go to 0). Read returns the current out_port value, zero-extended.
- addr 1 SET: write ORs writedata into LEVEL. Pulses are unaffected. Read returns 0.
- addr 2 CLEAR: write clears the LEVEL bits where writedata=1 and also cancels the pulses on those bits. Read returns 0.
- addr 3 PULSE: for each bit where writedata=1, the channel counter loads the effective length. Read returns the BUSY mask (bit i = counter i != 0).
- addr 4 LEN: write loads LEN from writedata[CNT_W-1:0]. Read returns LEN, zero-extended.
- addr 5..7: writes are ignored and reads return 0.
- Effective length is LEN, except that LEN=0 is treated as 1.
- Per-channel counter: while nonzero it decrements by 1 every clock. BUSY[i] = (cnt[i] != 0).
- Retrigger: a PULSE write to a busy bit reloads its counter, so the pulse is extended, not queued.
- A PULSE write on the same edge that a counter would reach 0: the reload wins.
- A LEN write affects only triggers after the write. Counters already running are unchanged.
- A pulse on a bit whose LEVEL=1 runs its counter normally, but out_port stays at 1 throughout.
- Reset: LEVEL=RESET_VALUE, LEN=DEFAULT_LEN, all counters 0, so out_port=RESET_VALUE.
- A reset asserted mid-pulse kills the pulse immediately; it is not reported or resumed.

## Timing
- Register writes take effect at the write edge. out_port reflects them in the cycle immediately following that edge (one-cycle latency from the write strobe).
- PULSE write at edge k: out_port[i]=1 for exactly L cycles, from edge k to edge k+L (L = effective length), then returns to LEVEL[i].
- BUSY read in any cycle between edge k and edge k+L returns 1 for that bit. From edge k+L onward it returns 0.
- readdata is combinational from address and current state. A read in the same cycle as a write returns the pre-write state.
- There are no wait states and no read latency; the block never stalls the bus.

## Test plan
- Reset: hold reset_n=0 with RESET_VALUE=8'hA5 and DEFAULT_LEN=4 -> out_port=8'hA5, LEN reads 4, BUSY reads 0. Assert reset_n asynchronously mid-cycle -> out_port changes without waiting for a clock edge.
- Level path: write LEVEL=8'h0F, then SET=8'h30, then CLEAR=8'h05 -> out_port reads 8'h0F, then 8'h3F, then 8'h3A, each one cycle after its write. Reads of SET and CLEAR return 0.
- Pulse length: write LEN=3, then PULSE=8'h01 -> out_port[0] is high for exactly 3 cycles and BUSY=1 during them. Repeat with LEN=0 -> high for exactly 1 cycle.
- Retrigger and cancel: LEN=10, PULSE bit 2, then PULSE bit 2 again 6 cycles later -> bit 2 is high for 16 cycles total. Then start a new pulse and write CLEAR bit 2 after 3 cycles -> bit 2 drops the next cycle and BUSY[2]=0.
- LEN change mid-pulse and LEVEL write: LEN=8, PULSE bit 1, write LEN=2 after 1 cycle -> bit 1 still lasts 8 cycles. PULSE bits 0..3, then write LEVEL=0 -> all four bits drop the next cycle.
- Address decode: writes to addr 5..7 change nothing; reads of addr 5..7 return 32'h0. With WIDTH=1, writes of 32'hFFFFFFFE to LEVEL leave out_port=0.
